// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port word memory.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_strb,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t      state;
    logic        port_q;      // 1 = data port owns the access
    logic        we_q;
    logic        err_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] data_in_q;
`ifdef MEM_ARB_RR_EN
    logic        ptr_q;       // 1 = data port preferred on contention
`endif

    logic        grant_d;
    logic        any_req;
    logic [31:0] sel_addr;
    logic [31:0] word_idx;
    logic        accept_err;
    logic [31:0] merged;

    always_comb begin
        any_req = i_req_valid | d_req_valid;
`ifdef MEM_ARB_RR_EN
        if (i_req_valid && d_req_valid) begin
            grant_d = ptr_q;
        end else begin
            grant_d = d_req_valid;
        end
`else
        grant_d = d_req_valid;
`endif
        sel_addr   = grant_d ? d_req_addr : i_req_addr;
        word_idx   = {2'b00, sel_addr[31:2]};
        accept_err = (sel_addr[1:0] != 2'b00) || (word_idx >= MEM_WORDS);
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = strb_q[k] ? wdata_q[8*k +: 8] : mem_data_out[8*k +: 8];
        end
    end

    assign i_req_ready      = (state == StIdle) && i_req_valid && !grant_d;
    assign d_req_ready      = (state == StIdle) && d_req_valid && grant_d;
    assign mem_address      = mem_addr_q;
    assign mem_data_in      = (state == StAccess) ? merged : data_in_q;
    assign mem_write_enable = (state == StAccess) && we_q && (strb_q != 4'b0000) && !err_q
                              && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            strb_q      <= 4'b0000;
            wdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            data_in_q   <= 32'h0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= 32'h0;
            i_rsp_err   <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= 32'h0;
            d_rsp_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        port_q     <= grant_d;
                        we_q       <= grant_d & d_req_we;
                        wdata_q    <= grant_d ? d_req_wdata : 32'h0;
                        strb_q     <= grant_d ? d_req_strb : 4'b0000;
                        err_q      <= accept_err;
                        mem_addr_q <= word_idx;
`ifdef MEM_ARB_RR_EN
                        ptr_q      <= ~grant_d;
`endif
                        state      <= StAccess;
                    end
                end
                StAccess: begin
                    data_in_q <= merged;
                    if (port_q) begin
                        d_rsp_valid <= 1'b1;
                        d_rsp_err   <= err_q;
                        d_rsp_data  <= (!we_q && !err_q) ? mem_data_out : 32'h0;
                    end else begin
                        i_rsp_valid <= 1'b1;
                        i_rsp_err   <= err_q;
                        i_rsp_data  <= err_q ? 32'h0 : mem_data_out;
                    end
                    state <= StResp;
                end
                StResp: begin
                    i_rsp_valid <= 1'b0;
                    d_rsp_valid <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural word memory attached.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_strb;
    logic        mem_write_enable;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    rsp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    logic        tb_ptr = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WORDS(4096)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    assign mem_data_out = (mem_address < 32'd4096) ? mem[mem_address[11:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable && mem_address < 32'd4096) mem[mem_address[11:0]] <= mem_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected response for an access accepted now, in acceptance order.
    task automatic push_exp(input logic port, input logic [31:0] addr, input logic we,
                            input logic [31:0] wd, input logic [3:0] strb);
        rsp_t        e;
        logic [31:0] idx;
        idx    = {2'b00, addr[31:2]};
        e.port = port;
        e.err  = (addr[1:0] != 2'b00) || (idx >= 32'd4096);
        e.data = 32'h0;
        e.cyc  = cyc;
        if (!we && !e.err) e.data = ref_mem[idx[11:0]];
        if (we && !e.err) begin
            for (int k = 0; k < 4; k++) begin
                if (strb[k]) ref_mem[idx[11:0]][8*k +: 8] = wd[8*k +: 8];
            end
        end
        exp_q.push_back(e);
        tb_ptr = ~port;
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (mem_write_enable) we_cnt++;
        if (i_rsp_valid && d_rsp_valid) chk("both_rsp", 1, 0);
        if (i_rsp_valid || d_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_rsp", {31'h0, d_rsp_valid}, 32'hffffffff);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_port", {31'h0, d_rsp_valid}, {31'h0, e.port});
                chk("rsp_lat", cyc - e.cyc, 2);
                if (e.port) begin
                    chk("d_data", d_rsp_data, e.data);
                    chk("d_err", {31'h0, d_rsp_err}, {31'h0, e.err});
                end else begin
                    chk("i_data", i_rsp_data, e.data);
                    chk("i_err", {31'h0, i_rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    task automatic do_req(input logic port, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic [3:0] strb);
        bit done = 0;
        @(posedge clk); #1;
        if (port) begin
            d_req_valid = 1; d_req_addr = addr; d_req_we = we; d_req_wdata = wd; d_req_strb = strb;
        end else begin
            i_req_valid = 1; i_req_addr = addr;
        end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (port ? d_req_ready : i_req_ready) begin
                chk("other_rdy", {31'h0, port ? i_req_ready : d_req_ready}, 0);
                push_exp(port, addr, port & we, wd, strb);
                done = 1;
            end
        end
        if (!done) chk("req_timeout", 0, 1);
        @(posedge clk); #1;
        i_req_valid = 0; d_req_valid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        tb_ptr = 1'b0;
    endtask

    // Both ports valid every cycle; grant order follows the arbitration model.
    task automatic contend(input int grants);
        int   got = 0;
        logic p;
        logic expp;
        @(posedge clk); #1;
        i_req_valid = 1; i_req_addr = 32'h0;
        d_req_valid = 1; d_req_addr = 32'h40; d_req_we = 0; d_req_strb = 4'h0;
        for (int n = 0; n < grants * 4 && got < grants; n++) begin
            @(negedge clk);
            if (i_req_ready && d_req_ready) chk("dual_rdy", 1, 0);
            if (i_req_ready || d_req_ready) begin
                p = d_req_ready;
`ifdef MEM_ARB_RR_EN
                expp = tb_ptr;
`else
                expp = 1'b1;
`endif
                chk("grant", {31'h0, p}, {31'h0, expp});
                push_exp(p, p ? 32'h40 : 32'h0, 1'b0, 32'h0, 4'h0);
                got++;
            end
        end
        chk("contend_cnt", got, grants);
        @(posedge clk); #1;
        d_req_valid = 0;
        got = 0;
        for (int n = 0; n < 10 && got == 0; n++) begin
            @(negedge clk);
            if (d_req_ready) chk("d_rdy_dropped", 1, 0);
            if (i_req_ready) begin
                push_exp(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
                got = 1;
            end
        end
        chk("i_after_drop", got, 1);
        @(posedge clk); #1;
        i_req_valid = 0;
    endtask

    initial begin
        int   w0;
        bit   seen;
        for (int k = 0; k < 4096; k++) begin
            mem[k] = 32'h0; ref_mem[k] = 32'h0;
        end
        mem[0] = 32'h00000013;  ref_mem[0] = 32'h00000013;
        mem[32] = 32'h12345678; ref_mem[32] = 32'h12345678;
        reset = 1;
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_strb = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_i_rdy", {31'h0, i_req_ready}, 0);
        chk("rst_d_rdy", {31'h0, d_req_ready}, 0);
        chk("rst_i_vld", {31'h0, i_rsp_valid}, 0);
        chk("rst_d_vld", {31'h0, d_rsp_valid}, 0);
        chk("rst_we", {31'h0, mem_write_enable}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_din", mem_data_in, 0);
        chk("rst_d_data", d_rsp_data, 0);

        // Full-word store then load.
        w0 = we_cnt;
        do_req(1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF);
        do_req(1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
        drain();
        chk("we_full", we_cnt - w0, 1);

        // Byte merge, then zero-strobe no-op.
        do_req(1'b1, 32'h40, 1'b1, 32'h00AA0000, 4'b0100);
        do_req(1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
        w0 = we_cnt;
        do_req(1'b1, 32'h40, 1'b1, 32'hFFFFFFFF, 4'b0000);
        do_req(1'b1, 32'h40, 1'b0, 32'h0, 4'h0);
        drain();
        chk("we_nostrb", we_cnt - w0, 0);
        chk("merge_mem", mem[16], 32'hDEAABEEF);

        // Misaligned load and out-of-range store.
        do_req(1'b1, 32'h41, 1'b0, 32'h0, 4'h0);
        w0 = we_cnt;
        do_req(1'b1, 32'h4000, 1'b1, 32'h55555555, 4'hF);
        drain();
        chk("we_oob", we_cnt - w0, 0);

        // Fetch path, including a misaligned fetch.
        do_req(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        do_req(1'b0, 32'h2, 1'b0, 32'h0, 4'h0);
        drain();

        // Reset in the ACCESS cycle of a store to 0x80.
        @(posedge clk); #1;
        d_req_valid = 1; d_req_addr = 32'h80; d_req_we = 1; d_req_wdata = 32'hCAFEF00D;
        d_req_strb = 4'hF;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = d_req_ready;
        end
        chk("rst_acc_rdy", {31'h0, seen}, 1);
        @(posedge clk); #1;
        d_req_valid = 0; reset = 1;
        @(negedge clk);
        chk("rst_acc_we", {31'h0, mem_write_enable}, 0);
        @(posedge clk); #1;
        reset = 0; tb_ptr = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", {31'h0, d_rsp_valid}, 0);
        chk("post_rst_addr", mem_address, 0);
        chk("post_rst_din", mem_data_in, 0);
        chk("post_rst_we", {31'h0, mem_write_enable}, 0);
        chk("post_rst_data", d_rsp_data, 0);
        chk("rst_acc_mem", mem[32], 32'h12345678);
        do_req(1'b1, 32'h80, 1'b0, 32'h0, 4'h0);
        drain();

        // Contention from a fresh reset.
        do_reset();
        contend(6);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
